xdisp_scan: RTL and testbench

// - Parametrised multiplexed 7-segment display scanner for the picoVersat calculator top (xtop).
// - Replaces the fixed 4-digit Disp/Disp_sel logic.
// - Software writes a packed hex word; it is held in a shadow register and copied to the active register only at a frame boundary (no tearing).
// - Active digits are scanned out one at a time at a programmable refresh rate.

---
 rtl/xdisp_scan_pkg.sv | 60 ++++++
 rtl/xdisp_scan_xseg_dec.sv | 19 +
 rtl/xdisp_scan.sv | 193 +++++++++++++++++++
 tb/tb_xdisp_scan.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/xdisp_scan_pkg.sv
// -----------------------------------------------------------------------------
// xdisp_scan_pkg
// Shared types and constants for the multiplexed 7-segment display scanner.
//   - nibble_t / seg_t : hex digit and active-low segment vector types
//   - XDISP_BLANK      : full output blank (all segments and dp off)
//   - SEG_BLANK        : segment-only blank used for leading-zero blanking
//   - XSEG_0..XSEG_F   : active-low {g,f,e,d,c,b,a} patterns for hex digits
//   - seg_lookup()     : nibble -> segment pattern
// -----------------------------------------------------------------------------
package xdisp_scan_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam logic [7:0] XDISP_BLANK = 8'hFF;
    localparam seg_t       SEG_BLANK   = 7'h7F;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam seg_t XSEG_0 = 7'h40;
    localparam seg_t XSEG_1 = 7'h79;
    localparam seg_t XSEG_2 = 7'h24;
    localparam seg_t XSEG_3 = 7'h30;
    localparam seg_t XSEG_4 = 7'h19;
    localparam seg_t XSEG_5 = 7'h12;
    localparam seg_t XSEG_6 = 7'h02;
    localparam seg_t XSEG_7 = 7'h78;
    localparam seg_t XSEG_8 = 7'h00;
    localparam seg_t XSEG_9 = 7'h10;
    localparam seg_t XSEG_A = 7'h08;
    localparam seg_t XSEG_B = 7'h03;
    localparam seg_t XSEG_C = 7'h46;
    localparam seg_t XSEG_D = 7'h21;
    localparam seg_t XSEG_E = 7'h06;
    localparam seg_t XSEG_F = 7'h0E;

    function automatic seg_t seg_lookup(input nibble_t nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = XSEG_0;
            4'h1:    seg = XSEG_1;
            4'h2:    seg = XSEG_2;
            4'h3:    seg = XSEG_3;
            4'h4:    seg = XSEG_4;
            4'h5:    seg = XSEG_5;
            4'h6:    seg = XSEG_6;
            4'h7:    seg = XSEG_7;
            4'h8:    seg = XSEG_8;
            4'h9:    seg = XSEG_9;
            4'hA:    seg = XSEG_A;
            4'hB:    seg = XSEG_B;
            4'hC:    seg = XSEG_C;
            4'hD:    seg = XSEG_D;
            4'hE:    seg = XSEG_E;
            4'hF:    seg = XSEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/xdisp_scan_xseg_dec.sv
// -----------------------------------------------------------------------------
// xseg_dec
// Combinational hex nibble to active-low 7-segment decoder.
//   nib : in  4  hex digit
//   seg : out 7  segments {g,f,e,d,c,b,a}, 0 = lit
// -----------------------------------------------------------------------------
module xseg_dec
    import xdisp_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = seg_lookup(nib);
    end

endmodule

// File: rtl/xdisp_scan.sv
// -----------------------------------------------------------------------------
// xdisp_scan
// Multiplexed 7-segment display scanner. Software writes a packed hex word
// into a shadow register; it is copied to the active register only at a frame
// boundary so a frame is never torn. Active digits are scanned one at a time,
// each held REFRESH_CNT clock cycles.
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst        in   1           synchronous active-high reset
//   wr_en      in   1           write strobe
//   wr_data    in   4*N_DIGITS  packed nibbles, digit 0 rightmost
//   wr_dp      in   N_DIGITS    decimal point per digit (1 = lit)
//   Disp       out  8           active-low segments {dp,g,f,e,d,c,b,a}
//   Disp_sel   out  N_DIGITS    active-low one-cold digit enables
//   frame_done out  1           pulse after the last digit's slot ends
//
// Configuration macro
//   XDISP_LZ_BLANK_EN : when defined, leading zero digits (other than digit 0)
//                       have their segments blanked; dp is still driven.
// -----------------------------------------------------------------------------
module xdisp_scan
    import xdisp_scan_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_CNT = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4*N_DIGITS-1:0]   wr_data,
    input  logic [N_DIGITS-1:0]     wr_dp,
    output logic [7:0]              Disp,
    output logic [N_DIGITS-1:0]     Disp_sel,
    output logic                    frame_done
);

    localparam int                IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [4*N_DIGITS-1:0]   shd_nib_q,  shd_nib_d;
    logic [N_DIGITS-1:0]     shd_dp_q,   shd_dp_d;
    logic [4*N_DIGITS-1:0]   act_nib_q,  act_nib_d;
    logic [N_DIGITS-1:0]     act_dp_q,   act_dp_d;
    logic                    pend_q,     pend_d;
    logic [7:0]              disp_q,     disp_d;
    logic [N_DIGITS-1:0]     sel_q,      sel_d;
    logic                    fdone_q,    fdone_d;

    logic                    wrap_s;
    logic                    frame_bnd_s;
    logic [3:0]              sel_nib_s;
    logic                    sel_dp_s;
    logic                    sel_lz_s;
    logic [N_DIGITS-1:0]     lz_s;
    logic [6:0]              dec_seg_s;

    // Refresh counter, digit index and frame-boundary detection.
    always_comb begin
        wrap_s      = (cnt_q == CNT_LAST);
        frame_bnd_s = wrap_s && (idx_q == IDX_LAST);
        if (wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Shadow / active / pending update. A write landing exactly on the frame
    // boundary goes straight to the active register so it is not held back a
    // whole frame.
    always_comb begin
        shd_nib_d = shd_nib_q;
        shd_dp_d  = shd_dp_q;
        act_nib_d = act_nib_q;
        act_dp_d  = act_dp_q;
        pend_d    = pend_q;
        if (frame_bnd_s) begin
            pend_d = 1'b0;
            if (wr_en) begin
                shd_nib_d = wr_data;
                shd_dp_d  = wr_dp;
                act_nib_d = wr_data;
                act_dp_d  = wr_dp;
            end else if (pend_q) begin
                act_nib_d = shd_nib_q;
                act_dp_d  = shd_dp_q;
            end else begin
                act_nib_d = act_nib_q;
                act_dp_d  = act_dp_q;
            end
        end else if (wr_en) begin
            shd_nib_d = wr_data;
            shd_dp_d  = wr_dp;
            pend_d    = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

`ifdef XDISP_LZ_BLANK_EN
    logic lz_run_s;

    // Leading-zero mask: walk down from the top digit while digits stay zero.
    // Digit 0 is never included so a zero value still shows one digit.
    always_comb begin
        lz_run_s = 1'b1;
        lz_s     = {N_DIGITS{1'b0}};
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            lz_run_s = lz_run_s & (act_nib_q[4*i +: 4] == 4'h0);
            lz_s[i]  = lz_run_s;
        end
    end
`else
    assign lz_s = {N_DIGITS{1'b0}};
`endif

    // Select the nibble, dp and blank flag of the currently scanned digit.
    always_comb begin
        sel_nib_s = 4'h0;
        sel_dp_s  = 1'b0;
        sel_lz_s  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib_s = act_nib_q[4*i +: 4];
                sel_dp_s  = act_dp_q[i];
                sel_lz_s  = lz_s[i];
            end else begin
                sel_nib_s = sel_nib_s;
            end
        end
    end

    xseg_dec u_xseg_dec (
        .nib (sel_nib_s),
        .seg (dec_seg_s)
    );

    // Next values of the registered outputs.
    always_comb begin
        if (sel_lz_s) begin
            disp_d = {~sel_dp_s, SEG_BLANK};
        end else begin
            disp_d = {~sel_dp_s, dec_seg_s};
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            sel_d[i] = (idx_q != IDX_W'(i));
        end
        fdone_d = frame_bnd_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            shd_nib_q <= {(4*N_DIGITS){1'b0}};
            shd_dp_q  <= {N_DIGITS{1'b0}};
            act_nib_q <= {(4*N_DIGITS){1'b0}};
            act_dp_q  <= {N_DIGITS{1'b0}};
            pend_q    <= 1'b0;
            disp_q    <= XDISP_BLANK;
            sel_q     <= {N_DIGITS{1'b1}};
            fdone_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shd_nib_q <= shd_nib_d;
            shd_dp_q  <= shd_dp_d;
            act_nib_q <= act_nib_d;
            act_dp_q  <= act_dp_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            sel_q     <= sel_d;
            fdone_q   <= fdone_d;
        end
    end

    assign Disp       = disp_q;
    assign Disp_sel   = sel_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_xdisp_scan.sv
// -----------------------------------------------------------------------------
// tb_xdisp_scan
// Self-checking bench for xdisp_scan with N_DIGITS=4, REFRESH_CNT=4.
// Expected frame contents {digit3,digit2,digit1,digit0} are queued as each
// stimulus step is issued and popped when the DUT scans that frame out.
// -----------------------------------------------------------------------------
module tb_xdisp_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [7:0]  Disp;
    logic [3:0]  Disp_sel;
    logic        frame_done;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];

    localparam logic [31:0] F_ZERO = 32'hC0C0C0C0;
    localparam logic [31:0] F_12AF = 32'hF9A4888E;
    localparam logic [31:0] F_0003 = 32'hC0C0C0B0;
    localparam logic [31:0] F_2222 = 32'hA424A4A4;
`ifdef XDISP_LZ_BLANK_EN
    localparam logic [31:0] F_0042 = 32'hFFFF99A4;
    localparam logic [31:0] F_LZ0  = 32'hFFFFFFC0;
`else
    localparam logic [31:0] F_0042 = 32'hC0C099A4;
    localparam logic [31:0] F_LZ0  = 32'hC0C0C0C0;
`endif

    always #5 clk = ~clk;

    xdisp_scan #(
        .N_DIGITS    (4),
        .REFRESH_CNT (4),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .Disp       (Disp),
        .Disp_sel   (Disp_sel),
        .frame_done (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scan one aligned frame (16 cycles), checking every cycle against the
    // popped expectation. Up to two writes are issued at tick indices wa / wb
    // (driven after that tick, sampled on the following edge).
    task automatic run_frame(input string tag,
                             input int wa, input logic [15:0] da, input logic [3:0] pa,
                             input int wb, input logic [15:0] db, input logic [3:0] pb);
        logic [31:0] exp;
        logic [3:0]  es;
        int          slot;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
            exp = 32'hFFFFFFFF;
        end else begin
            exp = sb_q.pop_front();
        end
        for (int j = 0; j < 16; j++) begin
            tick();
            slot = j / 4;
            es = 4'hF;
            es[slot] = 1'b0;
            check($sformatf("%s sel j=%0d", tag, j), {4'h0, Disp_sel}, {4'h0, es});
            check($sformatf("%s disp j=%0d", tag, j), Disp, exp[8*slot +: 8]);
            check($sformatf("%s fdone j=%0d", tag, j), {7'h00, frame_done},
                  (j == 15) ? 8'h01 : 8'h00);
            if (j == wa) begin
                wr_en = 1'b1; wr_data = da; wr_dp = pa;
            end else if (j == wb) begin
                wr_en = 1'b1; wr_data = db; wr_dp = pb;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 16'h0000; wr_dp = 4'h0;
        tick();
        tick();
        check("reset disp",  Disp, 8'hFF);
        check("reset sel",   {4'h0, Disp_sel}, 8'h0F);
        check("reset fdone", {7'h00, frame_done}, 8'h00);
        rst = 1'b0;

        // Plain scan of an all-zero display.
        sb_q.push_back(F_ZERO);
        run_frame("scan", -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Write mid-frame: held until the frame boundary.
        sb_q.push_back(F_ZERO);
        run_frame("preload", 4, 16'h12AF, 4'h0, -1, 16'h0, 4'h0);

        // 12AF shown; write landing on the boundary cycle.
        sb_q.push_back(F_12AF);
        run_frame("load12af", 14, 16'h0003, 4'h0, -1, 16'h0, 4'h0);

        // Collision write visible immediately; two writes, last wins with dp.
        sb_q.push_back(F_0003);
        run_frame("collide", 2, 16'h1111, 4'h0, 6, 16'h2222, 4'b0100);

        sb_q.push_back(F_2222);
        run_frame("dp_last", 3, 16'h0042, 4'h0, -1, 16'h0, 4'h0);

        sb_q.push_back(F_0042);
        run_frame("lz42", 3, 16'h0000, 4'h0, -1, 16'h0, 4'h0);

        sb_q.push_back(F_LZ0);
        run_frame("lz0", -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Pending write then reset mid-frame: the write must be discarded.
        wr_en = 1'b1; wr_data = 16'h5678; wr_dp = 4'hF;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst disp",  Disp, 8'hFF);
        check("midrst sel",   {4'h0, Disp_sel}, 8'h0F);
        check("midrst fdone", {7'h00, frame_done}, 8'h00);
        rst = 1'b0;
        sb_q.push_back(F_ZERO);
        sb_q.push_back(F_ZERO);
        run_frame("postrst0", -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("postrst1", -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
